// File: rtl/mem_access_unit.sv
// Initiator side of the RAM port: turns one CPU load/store request at a time into a RAM cycle,
// waits the RAM read latency, and returns an extended, single-cycle response.
module mem_access_unit #(
  parameter int unsigned RAM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic [1:0]  ram_mem_sz,
  output logic        ram_we,
  input  logic [31:0] ram_rdata
);

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE, so busy-time requests are simply left waiting.
  typedef enum logic [2:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP, S_ERR} state_t;

  localparam logic [3:0] LAT_M1 = 4'(RAM_LAT - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  sz_q, sz_d;
  logic        we_q, we_d;
  logic        store_q, store_d;
  logic        uns_q, uns_d;
  logic        misaligned;

  assign misaligned = (req_size == 2'd3) ||
                      ((req_size == 2'd1) && req_addr[0]) ||
                      ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      sz_q    <= '0;
      we_q    <= 1'b0;
      store_q <= 1'b0;
      uns_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      sz_q    <= sz_d;
      we_q    <= we_d;
      store_q <= store_d;
      uns_q   <= uns_d;
    end
  end

  // The write strobe defaults low so it is high only for the single ACCESS cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    sz_d    = sz_q;
    we_d    = 1'b0;
    store_d = store_q;
    uns_d   = uns_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (misaligned) begin
            state_d = S_ERR;
          end else begin
            addr_d  = req_addr;
            wdata_d = req_wdata;
            sz_d    = req_size;
            we_d    = req_we;
            store_d = req_we;
            uns_d   = req_unsigned;
            state_d = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        cnt_d   = LAT_M1;
        state_d = (RAM_LAT > 1) ? S_WAIT : S_RESP;
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign req_ready  = (state_q == S_IDLE);
  assign rsp_valid  = (state_q == S_RESP) || (state_q == S_ERR);
  assign rsp_err    = (state_q == S_ERR);
  assign ram_addr   = addr_q;
  assign ram_wdata  = wdata_q;
  assign ram_mem_sz = sz_q;
  assign ram_we     = we_q;

  // RAM data is valid in the RESP cycle itself, so extension is combinational there.
  always_comb begin
    rsp_rdata = '0;
    if ((state_q == S_RESP) && !store_q) begin
      case (sz_q)
        2'd0:    rsp_rdata = {{24{~uns_q & ram_rdata[7]}}, ram_rdata[7:0]};
        2'd1:    rsp_rdata = {{16{~uns_q & ram_rdata[15]}}, ram_rdata[15:0]};
        default: rsp_rdata = ram_rdata;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte-addressed RAM model with read latency, randomized requests,
// a reference memory for expected responses, and a scoreboard monitor.
module tb_mem_access_unit;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [1:0]  req_size = '0;
  logic        req_unsigned = 1'b0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [1:0]  ram_mem_sz;
  logic        ram_we;
  logic [31:0] ram_rdata;

  mem_access_unit #(.RAM_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_mem_sz(ram_mem_sz),
    .ram_we(ram_we), .ram_rdata(ram_rdata)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- RAM model (environment) ----------------
  logic [7:0]  ram_mem [256];
  logic [31:0] rd_pipe [LAT];
  assign ram_rdata = rd_pipe[LAT-1];

  always @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++)
        if (i < (1 << ram_mem_sz)) ram_mem[ram_addr[7:0] + 8'(i)] = ram_wdata[8*i +: 8];
    end
    rd_pipe[0] <= {ram_mem[ram_addr[7:0] + 8'd3], ram_mem[ram_addr[7:0] + 8'd2],
                   ram_mem[ram_addr[7:0] + 8'd1], ram_mem[ram_addr[7:0]]};
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  // ---------------- reference model ----------------
  logic [7:0] ref_mem [256];

  function automatic bit ref_misaligned(input logic [31:0] a, input logic [1:0] sz);
    if (sz == 2'd3) return 1'b1;
    return (a % (32'd1 << sz)) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz,
                                           input logic uns);
    longint unsigned v;
    int nb;
    logic [7:0] ix;
    nb = 1 << sz;
    v = 0;
    for (int i = 0; i < nb; i++) begin
      ix = a[7:0] + 8'(i);
      v = v + (longint'(ref_mem[ix]) << (8 * i));
    end
    if (nb < 4 && !uns && v >= (64'd1 << (8 * nb - 1)))
      v = v + 64'h1_0000_0000 - (64'd1 << (8 * nb));
    return v[31:0];
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    logic [7:0] ix;
    for (int i = 0; i < (1 << sz); i++) begin
      ix = a[7:0] + 8'(i);
      ref_mem[ix] = d[8*i +: 8];
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        store;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  sz;
    int          acc_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   we_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %0s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_quiet_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    check({tag, "_ram_addr"}, ram_addr, 32'd0);
    check({tag, "_ram_wdata"}, ram_wdata, 32'd0);
    check({tag, "_ram_mem_sz"}, 32'(ram_mem_sz), 32'd0);
    check({tag, "_ram_we"}, 32'(ram_we), 32'd0);
  endtask

  // Monitor: checks busy-time behaviour and pops one expectation per response pulse.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      exp_q.delete();
      we_cnt = 0;
    end else begin
      if (ram_we) we_cnt++;
      if (exp_q.size() > 0 && cyc > exp_q[0].acc_cyc) begin
        check("busy_req_ready", 32'(req_ready), 32'd0);
        if (!exp_q[0].err) begin
          check("ram_addr", ram_addr, exp_q[0].addr);
          check("ram_mem_sz", 32'(ram_mem_sz), 32'(exp_q[0].sz));
          if (exp_q[0].store) check("ram_wdata", ram_wdata, exp_q[0].wdata);
        end
      end
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", 32'(rsp_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("rsp_rdata", rsp_rdata, e.rdata);
          check("rsp_err", 32'(rsp_err), 32'(e.err));
          check("rsp_latency", 32'(cyc - e.acc_cyc), e.err ? 32'd1 : 32'(LAT + 1));
          check("ram_we_cycles", 32'(we_cnt), (e.store && !e.err) ? 32'd1 : 32'd0);
          we_cnt = 0;
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] sz, input logic uns);
    exp_t e;
    int guard;
    @(negedge clk);
    req_valid = 1'b1;
    req_we = we;
    req_addr = a;
    req_wdata = d;
    req_size = sz;
    req_unsigned = uns;
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      check("req_ready_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    e.err = ref_misaligned(a, sz);
    e.store = we;
    e.addr = a;
    e.wdata = d;
    e.sz = sz;
    e.acc_cyc = cyc;
    e.rdata = (e.err || we) ? 32'd0 : ref_load(a, sz, uns);
    if (!e.err && we) ref_store(a, sz, d);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we = 1'($urandom_range(0, 1));
    req_addr = $urandom;
    req_wdata = $urandom;
    req_size = 2'($urandom_range(0, 3));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0]  b;
    logic [1:0]  sz;
    logic [31:0] a;
    int          pick;
    int          guard;
    for (int i = 0; i < 256; i++) begin
      b = 8'($urandom);
      ram_mem[i] = b;
      ref_mem[i] = b;
    end
    repeat (3) @(negedge clk);
    check_quiet_outputs("reset");
    rst_n = 1'b1;

    issue(1'b1, 32'h10, 32'hDEADBEEF, 2'd2, 1'b0);
    issue(1'b0, 32'h10, 32'h0, 2'd2, 1'b0);
    issue(1'b1, 32'h21, 32'h1234_5680, 2'd0, 1'b0);
    issue(1'b0, 32'h21, 32'h0, 2'd0, 1'b0);
    issue(1'b0, 32'h21, 32'h0, 2'd0, 1'b1);
    issue(1'b1, 32'h22, 32'hABCD_8001, 2'd1, 1'b0);
    issue(1'b0, 32'h22, 32'h0, 2'd1, 1'b0);
    issue(1'b0, 32'h22, 32'h0, 2'd1, 1'b1);
    issue(1'b0, 32'h23, 32'h0, 2'd1, 1'b0);
    issue(1'b0, 32'h02, 32'h0, 2'd2, 1'b0);
    issue(1'b1, 32'h06, 32'h5555_AAAA, 2'd2, 1'b0);
    issue(1'b0, 32'h00, 32'h0, 2'd3, 1'b0);

    for (int n = 0; n < 80; n++) begin
      pick = $urandom_range(0, 9);
      sz = (pick < 3) ? 2'd0 : (pick < 6) ? 2'd1 : (pick < 9) ? 2'd2 : 2'd3;
      a = 32'($urandom_range(0, 255));
      if (sz != 2'd3 && $urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(1'($urandom_range(0, 1)), a, $urandom, sz, 1'($urandom_range(0, 1)));
    end

    // Abort a load while it sits in WAIT.
    issue(1'b0, 32'h40, 32'h0, 2'd2, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_quiet_outputs("mid_reset");
    repeat (3) begin
      @(negedge clk);
      check("reset_no_rsp", 32'(rsp_valid), 32'd0);
    end
    rst_n = 1'b1;
    issue(1'b0, 32'h40, 32'h0, 2'd2, 1'b0);

    guard = 0;
    while (exp_q.size() > 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("drain_pending", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
